// File: rtl/conv_fmap_drain_pkg.sv
// Shared types and index widths for the channel sequencer and the convolution engine.
package conv_fmap_drain_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned OUT_H_DEF = 12;
    localparam int unsigned OUT_W_DEF = 11;
    localparam int unsigned CHAN_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_fmap_drain_requant.sv
// Combinational bias add, ReLU, requantising shift and saturation for one pixel.
// Optional round-half-up before the shift when FMAP_ROUND_EN is defined.
module fmap_requant #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] i_pix,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    output logic        [OUT_WIDTH-1:0]  o_data_c
);

    localparam int unsigned SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << OUT_WIDTH) - SW'(1);
`ifdef FMAP_ROUND_EN
    localparam logic signed [SW-1:0] HALF = SW'(1) << (SHIFT - 1);
`endif

    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_adj;
    logic signed [SW-1:0] w_q;

    // Two guard bits keep both the bias add and the rounding add overflow-free
    always_comb begin
        w_sum = SW'(i_pix) + SW'(i_bias);
`ifdef FMAP_ROUND_EN
        w_adj = w_sum + HALF;
`else
        w_adj = w_sum;
`endif
        w_q = w_adj >>> SHIFT;
        if (w_sum[SW-1]) begin
            o_data_c = '0;
        end else if (w_q > SAT_MAX) begin
            o_data_c = '1;
        end else begin
            o_data_c = w_q[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_fmap_drain.sv
// Channel sequencer: triggers the conv engine per channel, then streams its result buffer
// through fmap_requant. Build option FMAP_ROUND_EN selects rounding in the requantiser.
module conv_fmap_drain
    import conv_fmap_drain_pkg::*;
#(
    parameter int unsigned OUT_H      = OUT_H_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF,
    parameter int unsigned CHAN       = CHAN_DEF,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic                         o_conv_trigger,
    output logic [IDX_W-1:0]             o_conv_chan,
    input  logic                         i_conv_valid,
    input  logic [IDX_W-1:0]             i_conv_out_chan,
    input  logic signed [DATA_WIDTH-1:0] i_fmap [OUT_H][OUT_W],
    input  logic signed [DATA_WIDTH-1:0] i_bias [CHAN],
    output logic                         o_m_valid,
    input  logic                         i_m_ready,
    output logic [OUT_WIDTH-1:0]         o_m_data,
    output logic [IDX_W-1:0]             o_m_chan,
    output logic [IDX_W-1:0]             o_m_row,
    output logic [IDX_W-1:0]             o_m_col,
    output logic                         o_m_last
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(OUT_H - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(CHAN - 1);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_ch, w_ch_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_busy, r_done, r_trig;
    logic                   r_m_valid, r_m_last;
    logic [OUT_WIDTH-1:0]   r_m_data;
    logic [IDX_W-1:0]       r_m_chan, r_row, r_col;
    logic                   w_hs, w_load;
    logic [IDX_W-1:0]       w_nrow, w_ncol;
    logic [OUT_WIDTH-1:0]   w_data_c;

    assign w_hs = r_m_valid & i_m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = TRIG;
            TRIG:    w_state_nxt = WAIT;
            WAIT:    if (i_conv_valid) w_state_nxt = DRAIN;
            DRAIN:   if (w_hs && r_m_last) w_state_nxt = (r_ch == LAST_CH) ? DONE : TRIG;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next channel/error and the coordinates of the pixel to load into the output register
    always_comb begin
        w_ch_nxt  = r_ch;
        w_err_nxt = r_err;
        w_load    = 1'b0;
        w_nrow    = r_row;
        w_ncol    = r_col;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_ch_nxt  = '0;
                    w_err_nxt = 1'b0;
                end
            end
            WAIT: begin
                if (i_conv_valid) begin
                    w_load = 1'b1;
                    w_nrow = '0;
                    w_ncol = '0;
                    if (i_conv_out_chan != r_ch) w_err_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (w_hs) begin
                    if (r_m_last) begin
                        if (r_ch != LAST_CH) w_ch_nxt = r_ch + IDX_W'(1);
                    end else begin
                        w_load = 1'b1;
                        if (r_col == LAST_COL) begin
                            w_nrow = r_row + IDX_W'(1);
                            w_ncol = '0;
                        end else begin
                            w_ncol = r_col + IDX_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    fmap_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_requant (
        .i_pix    (i_fmap[w_nrow][w_ncol]),
        .i_bias   (i_bias[r_ch]),
        .o_data_c (w_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch      <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_trig    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_chan  <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_ch      <= w_ch_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (w_state_nxt == DONE);
            r_trig    <= (w_state_nxt == TRIG);
            r_m_valid <= (w_state_nxt == DRAIN);
            if (w_load) begin
                r_row    <= w_nrow;
                r_col    <= w_ncol;
                r_m_chan <= r_ch;
                r_m_data <= w_data_c;
                r_m_last <= (w_nrow == LAST_ROW) && (w_ncol == LAST_COL);
            end
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_conv_trigger = r_trig;
    assign o_conv_chan    = r_ch;
    assign o_m_valid      = r_m_valid;
    assign o_m_data       = r_m_data;
    assign o_m_chan       = r_m_chan;
    assign o_m_row        = r_row;
    assign o_m_col        = r_col;
    assign o_m_last       = r_m_last;

endmodule

// File: tb/tb_conv_fmap_drain.sv
// Directed bench for conv_fmap_drain with a 20-cycle engine model and a beat-order scoreboard.
module tb_conv_fmap_drain;

    localparam int H = 12;
    localparam int W = 11;
    localparam int C = 10;
    localparam int NPIX = H * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err, conv_trigger;
    logic [3:0] conv_chan;
    logic conv_valid = 1'b0;
    logic [3:0] conv_out_chan = 4'd0;
    logic signed [23:0] fmap [H][W];
    logic signed [23:0] bias [C];
    logic m_valid;
    logic m_ready = 1'b1;
    logic [7:0] m_data;
    logic [3:0] m_chan, m_row, m_col;
    logic m_last;

    int n_chk = 0;
    int n_bad = 0;

    int exp_kind = 0;
    int exp_const = 0;
    bit rnd_ready = 0;
    bit mm_mode = 0;

    int trig_run = 0;
    int beat = 0;
    int cur_ch = 0;
    int done_total = 0;
    bit eng_pend = 0;
    int eng_cnt = 0;
    logic [3:0] eng_ch = 4'd0;
    bit stalled = 0;
    logic [7:0] s_data;
    logic [3:0] s_chan, s_row, s_col;
    logic s_last;

    always #5 clk = ~clk;

    conv_fmap_drain dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_conv_trigger  (conv_trigger),
        .o_conv_chan     (conv_chan),
        .i_conv_valid    (conv_valid),
        .i_conv_out_chan (conv_out_chan),
        .i_fmap          (fmap),
        .i_bias          (bias),
        .o_m_valid       (m_valid),
        .i_m_ready       (m_ready),
        .o_m_data        (m_data),
        .o_m_chan        (m_chan),
        .o_m_row         (m_row),
        .o_m_col         (m_col),
        .o_m_last        (m_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_pix(input int b, input int ch);
        if (exp_kind == 0) return b;
        if (exp_kind == 1) return exp_const;
        return ch;
    endfunction

    // Engine model and stream monitor share one negedge process so their ordering is fixed
    always @(negedge clk) begin
        conv_valid = 1'b0;
        if (!rst_n) begin
            eng_pend = 0;
        end else if (conv_trigger) begin
            chk("trig_chan", 32'(conv_chan), 32'(trig_run));
            chk("err_at_trig", 32'(err), 32'(mm_mode && (conv_chan > 4'd3)));
            trig_run++;
            eng_pend = 1;
            eng_cnt = 20;
            eng_ch = conv_chan;
        end else if (eng_pend) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                conv_valid = 1'b1;
                conv_out_chan = (mm_mode && eng_ch == 4'd3) ? 4'(eng_ch + 4'd1) : eng_ch;
                eng_pend = 0;
            end
        end
        if (stalled) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(s_data));
            chk("stall_chan", 32'(m_chan), 32'(s_chan));
            chk("stall_row", 32'(m_row), 32'(s_row));
            chk("stall_col", 32'(m_col), 32'(s_col));
            chk("stall_last", 32'(m_last), 32'(s_last));
        end
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_valid && m_ready) begin
            chk("m_chan", 32'(m_chan), 32'(cur_ch));
            chk("m_row", 32'(m_row), 32'(beat / W));
            chk("m_col", 32'(m_col), 32'(beat % W));
            chk("m_last", 32'(m_last), 32'(beat == NPIX - 1));
            chk("m_data", 32'(m_data), 32'(exp_pix(beat, cur_ch)));
            beat++;
            if (beat == NPIX) begin
                beat = 0;
                cur_ch++;
            end
        end
        stalled = m_valid && !m_ready;
        s_data = m_data;
        s_chan = m_chan;
        s_row = m_row;
        s_col = m_col;
        s_last = m_last;
        if (done) done_total++;
        if (!busy) begin
            beat = 0;
            cur_ch = 0;
            trig_run = 0;
        end
    end

    task automatic set_fmap(input bit ramp, input logic signed [23:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                fmap[r][c] = ramp ? 24'((r * W + c) << 8) : v;
    endtask

    task automatic set_bias(input bit by_chan);
        for (int c = 0; c < C; c++) bias[c] = by_chan ? 24'(c << 8) : 24'sd0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_trig"}, 32'(conv_trigger), 32'd0);
        chk({pfx, "_cchan"}, 32'(conv_chan), 32'd0);
        chk({pfx, "_mvalid"}, 32'(m_valid), 32'd0);
        chk({pfx, "_mdata"}, 32'(m_data), 32'd0);
        chk({pfx, "_mchan"}, 32'(m_chan), 32'd0);
        chk({pfx, "_mrow"}, 32'(m_row), 32'd0);
        chk({pfx, "_mcol"}, 32'(m_col), 32'd0);
        chk({pfx, "_mlast"}, 32'(m_last), 32'd0);
    endtask

    task automatic run_pass(input int kind, input int cval, input bit rnd, input bit mm, input bit poke);
        bit got;
        exp_kind = kind;
        exp_const = cval;
        rnd_ready = rnd;
        mm_mode = mm;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            start = (poke && (i == 300 || i == 301));
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        chk("pass_done", 32'(got), 32'd1);
        if (got) begin
            chk("n_trig", 32'(trig_run), 32'(C));
            chk("n_beat", 32'(cur_ch * NPIX + beat), 32'(C * NPIX));
            chk("err_end", 32'(err), 32'(mm));
            @(negedge clk);
            chk("done_width", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int trig_seen;
        int dt;
        bit reached;
        set_fmap(1, 24'sd0);
        set_bias(0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // ramp, full-rate sink, start poked while busy
        run_pass(0, 0, 0, 0, 1);
        // same ramp with back-pressure
        run_pass(0, 0, 1, 0, 0);
        set_fmap(0, -24'sd256);
        run_pass(1, 0, 1, 0, 0);
        set_fmap(0, 24'sh7FFFFF);
        run_pass(1, 255, 0, 0, 0);
        set_fmap(0, 24'sh000180);
`ifdef FMAP_ROUND_EN
        run_pass(1, 2, 0, 0, 0);
`else
        run_pass(1, 1, 0, 0, 0);
`endif
        set_fmap(0, 24'sh00017F);
        run_pass(1, 1, 0, 0, 0);
        set_fmap(0, 24'sd0);
        set_bias(1);
        run_pass(2, 0, 0, 0, 0);
        set_fmap(1, 24'sd0);
        set_bias(0);
        run_pass(0, 0, 0, 1, 0);
        run_pass(0, 0, 0, 0, 0);

        // reset in the middle of channel 5
        exp_kind = 0;
        rnd_ready = 0;
        mm_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cur_ch == 5 && beat >= 3) begin
                reached = 1;
                break;
            end
        end
        chk("reach_ch5", 32'(reached), 32'd1);
        trig_seen = trig_run;
        chk("trig_by_ch5", 32'(trig_seen), 32'd6);
        dt = done_total;
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done", 32'(done_total), 32'(dt));
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_trig", 32'(conv_trigger), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
